// File: rtl/morse_scheduler.sv
// Morse letter scheduler: letter FIFO plus a playback FSM that drives the
// datapath load/shift strobes and the dot/dash LEDs in unit ticks.
module morse_scheduler #(
  parameter int DEPTH      = 4,
  parameter int DASH_UNITS = 3,
  parameter int LGAP_UNITS = 3
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       tick_i,
  input  logic       push_i,
  input  logic [2:0] letter_i,
  output logic       full_o,
  output logic [2:0] level_o,
  output logic       load_o,
  output logic [2:0] letter_o,
  output logic       shift_o,
  input  logic       data_i,
  input  logic [2:0] size_i,
  output logic       dot_o,
  output logic       dash_o,
  output logic       busy_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_WAIT = 3'd2,
    S_MARK = 3'd3,
    S_SGAP = 3'd4,
    S_LGAP = 3'd5
  } state_e;

  localparam int AW   = $clog2(DEPTH);
  localparam int MAXU = (DASH_UNITS > LGAP_UNITS) ? DASH_UNITS : LGAP_UNITS;
  localparam int CW   = $clog2(MAXU + 1);
  localparam logic [CW-1:0] DASH_N  = CW'(DASH_UNITS);
  localparam logic [CW-1:0] LGAP_N  = CW'(LGAP_UNITS);
  localparam logic [2:0]    DEPTH_N = 3'(DEPTH);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            first_q;
  logic            sym_q, sym_d;
  logic            last_q, last_d;
  logic [AW-1:0]   rd_q, wr_q;
  logic [2:0]      count_q, count_d;
  logic [2:0]      mem_q [DEPTH];
  logic [2:0]      letter_q, letter_d;
  logic            full_q, load_q, shift_q, shift_d;
  logic            dot_q, dash_q, busy_q;
  logic            tk, pop, push_ok, level_nz;
  logic [CW-1:0]   mark_n;

  // A tick on the first cycle of any state is ignored.
  assign tk       = tick_i & ~first_q;
  assign pop      = (state_q == S_LOAD);
  assign push_ok  = push_i & ((count_q != DEPTH_N) | pop);
  assign level_nz = (count_q != 3'd0) | push_i;
  assign mark_n   = sym_q ? DASH_N : CW'(1);

  always_comb begin
    count_d = count_q;
    if (push_ok & ~pop)
      count_d = count_q + 3'd1;
    else if (pop & ~push_ok)
      count_d = count_q - 3'd1;
  end

  always_comb begin
    state_d  = state_q;
    sym_d    = sym_q;
    last_d   = last_q;
    shift_d  = 1'b0;
    letter_d = letter_q;
    unique case (state_q)
      S_IDLE: if (count_q != 3'd0) state_d = S_LOAD;
      S_LOAD: state_d = S_WAIT;
      S_WAIT: begin
        if (size_i == 3'd0) begin
          state_d = S_IDLE;
        end else begin
          sym_d   = data_i;
          last_d  = (size_i == 3'd1);
          state_d = S_MARK;
        end
      end
      S_MARK: begin
        if (tk && (cnt_q + CW'(1)) == mark_n) begin
          shift_d = 1'b1;
          state_d = last_q ? S_LGAP : S_SGAP;
        end
      end
      S_SGAP: begin
        if (tk) begin
          sym_d   = data_i;
          last_d  = (size_i == 3'd1);
          state_d = S_MARK;
        end
      end
      S_LGAP: begin
        if (tk && (cnt_q + CW'(1)) == LGAP_N)
          state_d = level_nz ? S_LOAD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // An empty FIFO can only reach LOAD via a same-cycle push.
    if (state_d == S_LOAD)
      letter_d = (count_q == 3'd0) ? letter_i : mem_q[rd_q];
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)
      cnt_d = '0;
    else if (tk && (state_q == S_MARK || state_q == S_LGAP))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge CLOCK_50) begin
    if (push_ok) mem_q[wr_q] <= letter_i;
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      sym_q    <= 1'b0;
      last_q   <= 1'b0;
      rd_q     <= '0;
      wr_q     <= '0;
      count_q  <= 3'd0;
      full_q   <= 1'b0;
      letter_q <= 3'd0;
      load_q   <= 1'b0;
      shift_q  <= 1'b0;
      dot_q    <= 1'b0;
      dash_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      first_q  <= (state_d != state_q);
      sym_q    <= sym_d;
      last_q   <= last_d;
      if (pop)     rd_q <= rd_q + AW'(1);
      if (push_ok) wr_q <= wr_q + AW'(1);
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_N);
      letter_q <= letter_d;
      load_q   <= (state_d == S_LOAD);
      shift_q  <= shift_d;
      dot_q    <= (state_d == S_MARK) & ~sym_d;
      dash_q   <= (state_d == S_MARK) & sym_d;
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign full_o   = full_q;
  assign level_o  = count_q;
  assign load_o   = load_q;
  assign letter_o = letter_q;
  assign shift_o  = shift_q;
  assign dot_o    = dot_q;
  assign dash_o   = dash_q;
  assign busy_o   = busy_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_morse_scheduler.sv
// Bench for morse_scheduler: a behavioural letter datapath answers the
// load/shift strobes; directed vectors and sequences check the FSM and FIFO.
module tb_morse_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_i;
  logic       push_i;
  logic [2:0] letter_i;
  logic       full_o;
  logic [2:0] level_o;
  logic       load_o;
  logic [2:0] letter_o;
  logic       shift_o;
  logic       data_i;
  logic [2:0] size_i;
  logic       dot_o;
  logic       dash_o;
  logic       busy_o;
  logic [2:0] state_o;

  int nchk = 0;
  int nerr = 0;

  logic tick_en   = 1'b0;
  logic zero_mode = 1'b0;

  morse_scheduler dut (
    .CLOCK_50 (clk),
    .rst      (rst),
    .tick_i   (tick_i),
    .push_i   (push_i),
    .letter_i (letter_i),
    .full_o   (full_o),
    .level_o  (level_o),
    .load_o   (load_o),
    .letter_o (letter_o),
    .shift_o  (shift_o),
    .data_i   (data_i),
    .size_i   (size_i),
    .dot_o    (dot_o),
    .dash_o   (dash_o),
    .busy_o   (busy_o),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  // Symbol patterns, first symbol in bit 0 (1 = dash).
  function automatic logic [3:0] pat(input logic [2:0] l);
    case (l)
      3'd0: pat = 4'b0010;
      3'd1: pat = 4'b0001;
      3'd2: pat = 4'b0101;
      3'd3: pat = 4'b0001;
      3'd4: pat = 4'b0000;
      3'd5: pat = 4'b0100;
      3'd6: pat = 4'b0011;
      default: pat = 4'b0000;
    endcase
  endfunction

  function automatic logic [2:0] len(input logic [2:0] l);
    case (l)
      3'd0: len = 3'd2;
      3'd3: len = 3'd3;
      3'd4: len = 3'd1;
      3'd6: len = 3'd3;
      default: len = 3'd4;
    endcase
  endfunction

  logic [3:0] dp_bits = 4'd0;
  logic [2:0] dp_size = 3'd0;
  assign data_i = dp_bits[0];
  assign size_i = dp_size;

  always @(posedge clk) begin
    if (load_o) begin
      dp_bits <= pat(letter_o);
      dp_size <= zero_mode ? 3'd0 : len(letter_o);
    end else if (shift_o) begin
      dp_bits <= dp_bits >> 1;
      dp_size <= dp_size - 3'd1;
    end
  end

  int tph = 0;
  initial begin
    tick_i = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      tick_i = tick_en && (tph == 3);
      tph = (tph + 1) % 4;
    end
  end

  int loads = 0, shifts = 0, leds = 0, bad = 0;
  int dot_t = 0, dash_t = 0, sgap_t = 0, lgap_t = 0;
  int idle_run = 0;
  logic [2:0] prev_st = 3'd0;
  int ldq[$];
  int idleq[$];

  always @(posedge clk) begin
    if (load_o) begin
      loads++;
      ldq.push_back(int'(letter_o));
      idleq.push_back(idle_run);
      idle_run = 0;
    end
    if (state_o == 3'd0) idle_run++;
    if (shift_o) shifts++;
    if (tick_i && state_o == prev_st) begin
      if (state_o == 3'd3 && dot_o) dot_t++;
      if (state_o == 3'd3 && dash_o) dash_t++;
      if (state_o == 3'd4) sgap_t++;
      if (state_o == 3'd5) lgap_t++;
    end
    if (dot_o || dash_o) leds++;
    if ((dot_o && dash_o) || ((dot_o || dash_o) && state_o != 3'd3)) bad++;
    prev_st = state_o;
  end

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input string nm, input logic [2:0] s, input int mx);
    for (int i = 0; i < mx && state_o != s; i++) step();
    chk(nm, int'(state_o), int'(s));
  endtask

  task automatic wait_idle(input string nm, input int mx);
    for (int i = 0; i < mx && (busy_o || level_o != 3'd0); i++) step();
    chk(nm, int'(busy_o), 0);
  endtask

  task automatic push1(input logic [2:0] l);
    push_i = 1'b1;
    letter_i = l;
    step();
    push_i = 1'b0;
  endtask

  typedef struct {
    logic       push;
    logic [2:0] letter;
    int         lvl;
    int         full;
  } vec_t;

  vec_t vt[6];
  int   exp_ld[6];

  int s_ld, s_sh, s_dot, s_dash, s_sg, s_lg, s_led, s_q;

  task automatic snap();
    s_ld = loads; s_sh = shifts; s_dot = dot_t; s_dash = dash_t;
    s_sg = sgap_t; s_lg = lgap_t; s_led = leds; s_q = ldq.size();
  endtask

  initial begin
    vt[0] = '{1'b1, 3'd4, 1, 0};
    vt[1] = '{1'b1, 3'd5, 2, 0};
    vt[2] = '{1'b1, 3'd6, 3, 0};
    vt[3] = '{1'b1, 3'd7, 4, 1};
    vt[4] = '{1'b1, 3'd0, 4, 1};
    vt[5] = '{1'b0, 3'd0, 4, 1};
    exp_ld = '{3, 4, 5, 6, 7, 1};

    rst = 1'b1;
    push_i = 1'b0;
    letter_i = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst state", int'(state_o), 0);
    chk("rst level", int'(level_o), 0);
    chk("rst full", int'(full_o), 0);
    chk("rst load", int'(load_o), 0);
    chk("rst shift", int'(shift_o), 0);
    chk("rst leds", int'({dot_o, dash_o}), 0);
    chk("rst busy", int'(busy_o), 0);
    chk("rst letter", int'(letter_o), 0);
    rst = 1'b0;
    step();

    // Letter A: exact push-to-MARK latency, then timed playback.
    snap();
    push1(3'd0);
    chk("A level n+1", int'(level_o), 1);
    chk("A idle n+1", int'(state_o), 0);
    step();
    chk("A LOAD n+2", int'(state_o), 1);
    chk("A load_o", int'(load_o), 1);
    chk("A letter_o", int'(letter_o), 0);
    step();
    chk("A WAIT n+3", int'(state_o), 2);
    chk("A load_o off", int'(load_o), 0);
    step();
    chk("A MARK n+4", int'(state_o), 3);
    chk("A dot first", int'({dot_o, dash_o}), 2);
    tick_en = 1'b1;
    wait_idle("A idle", 2000);
    chk("A dot ticks", dot_t - s_dot, 1);
    chk("A dash ticks", dash_t - s_dash, 3);
    chk("A sgap ticks", sgap_t - s_sg, 1);
    chk("A lgap ticks", lgap_t - s_lg, 3);
    chk("A shifts", shifts - s_sh, 2);
    chk("A loads", loads - s_ld, 1);

    // B then C queued mid-play: C loads straight out of LGAP.
    snap();
    push1(3'd1);
    wait_state("B mark", 3'd3, 20);
    push1(3'd2);
    chk("C queued level", int'(level_o), 1);
    wait_idle("BC idle", 3000);
    chk("BC loads", loads - s_ld, 2);
    chk("BC first", ldq[s_q], 1);
    chk("BC second", ldq[s_q + 1], 2);
    chk("C no idle gap", idleq[s_q + 1], 0);
    chk("BC level", int'(level_o), 0);
    chk("BC shifts", shifts - s_sh, 8);
    chk("BC dot ticks", dot_t - s_dot, 5);
    chk("BC dash ticks", dash_t - s_dash, 9);

    // Fill the FIFO while D is held in MARK with ticks stopped.
    tick_en = 1'b0;
    step();
    snap();
    push1(3'd3);
    wait_state("D mark", 3'd3, 20);
    foreach (vt[i]) begin
      push_i = vt[i].push;
      letter_i = vt[i].letter;
      step();
      chk($sformatf("fill%0d level", i), int'(level_o), vt[i].lvl);
      chk($sformatf("fill%0d full", i), int'(full_o), vt[i].full);
    end
    push_i = 1'b0;
    tick_en = 1'b1;
    wait_state("full LOAD", 3'd1, 2000);
    push1(3'd1);
    chk("push+pop level", int'(level_o), 4);
    chk("push+pop full", int'(full_o), 1);
    wait_idle("fill idle", 6000);
    chk("fill loads", loads - s_ld, 6);
    for (int i = 0; i < 6; i++)
      if (s_q + i < ldq.size())
        chk($sformatf("fill order%0d", i), ldq[s_q + i], exp_ld[i]);
      else
        chk($sformatf("fill order%0d", i), -1, exp_ld[i]);

    // Reset while B shows its dash, with E still queued.
    push1(3'd1);
    wait_state("B2 mark", 3'd3, 20);
    push1(3'd4);
    chk("B2 dash on", int'(dash_o), 1);
    chk("B2 level", int'(level_o), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst dash", int'(dash_o), 0);
    chk("rst mid state", int'(state_o), 0);
    chk("rst mid level", int'(level_o), 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    snap();
    repeat (40) step();
    chk("post rst leds", leds - s_led, 0);
    chk("post rst loads", loads - s_ld, 0);
    chk("post rst state", int'(state_o), 0);

    // Zero-length letter goes WAIT -> IDLE silently.
    tick_en = 1'b0;
    zero_mode = 1'b1;
    step();
    snap();
    push1(3'd5);
    chk("Z idle", int'(state_o), 0);
    step();
    chk("Z LOAD", int'(state_o), 1);
    step();
    chk("Z WAIT", int'(state_o), 2);
    step();
    chk("Z back idle", int'(state_o), 0);
    repeat (5) step();
    chk("Z shifts", shifts - s_sh, 0);
    chk("Z leds", leds - s_led, 0);
    chk("Z busy", int'(busy_o), 0);
    zero_mode = 1'b0;

    chk("led exclusivity", bad, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/morse_scheduler.md
# morse_scheduler

Controller that queues letter requests and sequences the Morse display datapath (letter decoder, symbol shift register and symbol-count down-counter) to play them back-to-back. It owns a small letter FIFO, issues the datapath's load and shift strobes, and times dots, dashes, intra-letter gaps and inter-letter gaps in units of an external unit-tick strobe (the half-second divider output). It sits between the switch/key front end and the existing datapath and drives the dot/dash LEDs directly.

## Interface
- DEPTH, 4, letter FIFO entries (power of two, ≥2)
- DASH_UNITS, 3, dash length in ticks
- LGAP_UNITS, 3, inter-letter gap in ticks (intra-letter gap fixed at 1 tick)

- CLOCK_50  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- tick_i  in  1  one-cycle unit strobe
- push_i  in  1  enqueue letter_i this cycle
- letter_i  in  3  letter code 0..7 (A..H)
- full_o  out  1  FIFO full; push_i ignored unless a pop occurs same cycle
- level_o  out  3  FIFO occupancy 0..DEPTH
- load_o  out  1  one-cycle load strobe to datapath
- letter_o  out  3  letter presented to datapath, valid while load_o=1
- shift_o  out  1  one-cycle shift strobe to datapath
- data_i  in  1  current symbol from register (1=dash, 0=dot)
- size_i  in  3  symbols remaining incl. current, from counter
- dot_o  out  1  dot LED
- dash_o  out  1  dash LED
- busy_o  out  1  high whenever state ≠ IDLE
- state_o  out  3  encoded state for LEDR debug

## Operation
- Datapath contract: cycle after load_o, data_i/size_i show first symbol and full length; cycle after shift_o, they show next symbol and size_i decremented by 1.
- States (state_o): IDLE=0, LOAD=1, WAIT=2, MARK=3, SGAP=4, LGAP=5.
- IDLE: if level_o≠0 → LOAD; else stay. tick_i ignored.
- LOAD (1 cycle): pop FIFO head, load_o=1, letter_o=head → WAIT.
- WAIT (1 cycle): if size_i=0 → IDLE (empty letter, no LED activity); else latch sym=data_i, last=(size_i=1) → MARK.
- MARK: dot_o=~sym, dash_o=sym. Unit counter cleared on entry, +1 per tick_i. Exit on the tick_i that brings counter to 1 (dot) or DASH_UNITS (dash): shift_o=1 that cycle; → LGAP if last, else SGAP.
- SGAP: LEDs off; exit on 1st tick_i → MARK with sym=data_i, last=(size_i=1) sampled on exit cycle.
- LGAP: LEDs off; exit on LGAP_UNITS-th tick_i → LOAD if level_o≠0 (after any same-cycle push), else IDLE.
- FIFO: push accepted when not full, or when full and a pop occurs in the same cycle. Push while full without pop dropped silently. level_o updates next cycle; push+pop same cycle leaves level unchanged. Pointers wrap modulo DEPTH.
- dot_o and dash_o never both high; both low outside MARK.

## Timing
- Reset values: state IDLE, FIFO empty, level_o=0, full_o=0, load_o=shift_o=dot_o=dash_o=busy_o=0, letter_o=0, state_o=0.
- All outputs registered; reset takes effect immediately, no clock needed.
- Push → load_o latency from IDLE: push at cycle n, level_o=1 at n+1, LOAD (load_o=1) at n+2, MARK at n+4.
- Mark duration: from MARK entry to the 1st (dot) / DASH_UNITS-th (dash) tick_i; state leaves on the cycle after that tick.
- tick_i coinciding with a state's entry cycle is not counted.
- Reset mid-letter: LEDs off, FIFO flushed, no shift/load issued; stale datapath contents overwritten by next load_o.

## Test plan
- Reset then push A (0) once, tick_i every 4 cycles, size model A=".-": load_o 2 cycles after push, dot_o for 1 tick, gap 1 tick, dash_o for 3 ticks, shift_o twice, LGAP 3 ticks, then IDLE, busy_o=0.
- Push B (1, "-...") then C (2) while B plays: after B's LGAP, load_o issued directly for C with no IDLE cycle; level_o 1→0.
- Push 5 letters back-to-back in IDLE-blocked state (hold ticks off during playback): level_o saturates at 4, full_o=1, 5th push dropped, exactly 4 load_o pulses total.
- FIFO full and LOAD pop in same cycle as push_i: push accepted, level_o stays 4, new letter played last.
- Assert rst during dash_o of B: dash_o=0 and state_o=0 same cycle, level_o=0; after release, tick_i pulses produce no LED activity until new push.
- Datapath model returns size_i=0 on load: WAIT → IDLE, no dot_o/dash_o/shift_o.
